tt_um_murra232_delay_line: RTL and testbench
============================================

# tt_um_Murra232_delay_line

Parametrised successor to the team's single-bit D flip-flop tile: a WIDTH-bit, DEPTH-stage clock-enabled delay line with per-sample valid bits. It has a run-time selectable output tap, a synchronous clear, occupancy flags and a drop indicator. It sits directly on the Tiny Tapeout user-tile pins as a top-level `tt_um_` module.

## Interface
Parameters:
- WIDTH, 4, data bits per sample; legal range 1..4.
- DEPTH, 8, number of stages; a power of two, 2..8.
- TAPW, derived as clog2(DEPTH); width of the tap select.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ui_in  in  8  [WIDTH-1:0] din; [4] vin (sample valid); [5] en (advance); [6] sclr (sync clear); [7] tap_ld.
- uio_in  in  8  [TAPW-1:0] tap value, taken when tap_ld=1; other bits ignored.
- uo_out  out  8  [WIDTH-1:0] dout; [4] vout; [5] full; [6] empty; [7] drop. Unused bits in [3:0] are driven 0.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all inputs).
- ena  in  1  ignored.

## Operation
- State:
  - stages s[0..DEPTH-1], each holding {valid, data[WIDTH-1:0]};
  - tap_q[TAPW-1:0];
  - occupancy counter cnt[TAPW:0];
  - drop_q.
- Update priority per edge is rst_n, then sclr, then en.
- rst_n=0: all stages, tap_q, cnt and drop_q go to 0.
- sclr=1 (rst_n=1):
  - all stage valid and data bits go to 0;
  - cnt and drop_q go to 0;
  - tap_q is retained unless tap_ld=1 in the same cycle.
- en=1 (no sclr):
  - s[0] takes {vin, din};
  - s[i] takes s[i-1] for i = 1..DEPTH-1.
- en=0: stages hold.
- tap_ld=1 (rst_n=1): tap_q takes uio_in[TAPW-1:0]. This is independent of en and sclr.
- Outputs:
  - dout = s[tap_q].data and vout = s[tap_q].valid, muxed combinationally from registers.
  - full = (cnt==DEPTH); empty = (cnt==0).
  - drop = drop_q.
- cnt, when en=1:
  - +1 if vin=1 and s[DEPTH-1].valid=0;
  - −1 if vin=0 and s[DEPTH-1].valid=1;
  - otherwise unchanged.
- cnt holds when en=0. It never wraps; the range is 0..DEPTH by construction.
- drop_q is set to 1 for exactly one cycle after an edge with en=1 and s[DEPTH-1].valid=1, i.e. a valid sample is shifted out. Otherwise it is 0.
- cnt counts all stages, not just those up to the tap.

## Timing
- Delay: a sample captured at enabled edge k appears on dout/vout after enabled edge k+tap_q, i.e. tap_q+1 enabled edges in total.
- tap=0 reproduces the plain D flip-flop, with 1 cycle of latency.
- With en=0 the output is frozen, except that a tap change re-selects a different stage.
- Tap change: the new tap takes effect immediately after the loading edge. There is no flush and no intermediate value.
- full, empty and drop are all valid the cycle after the causing edge.
- Reset is asserted mid-stream: after the edge, all outputs are 0 except empty=1. Contents are not preserved.
- sclr and en together: sclr wins, and din/vin from that cycle are discarded.
- sclr and tap_ld together: the pipe is cleared and the new tap is loaded.
- Simultaneous in/out (en=1, vin=1, last stage valid): cnt is unchanged and drop pulses.
- DEPTH=2: TAPW=1. Only uio_in[0] is used.

## Structure
- Shared package tt_delay_pkg:
  - default WIDTH/DEPTH constants;
  - ui_in/uo_out bit-index localparams (VIN, EN, SCLR, TAPLD, VOUT, FULL, EMPTY, DROP);
  - a stage struct typedef {valid, data}.
- Sub-module delay_stage: one {valid, data} register with enable and synchronous clear, instantiated DEPTH times via generate.
- The top level holds tap_q, cnt, drop_q and the output mux.

## Test plan
- Reset and flags:
  - Stimulus: rst_n=0 for 2 cycles.
  - Required: uo_out=0x40 (empty=1, all others 0).
  - Stimulus: hold en=0 and toggle din.
  - Required: outputs unchanged.
- Tap 0, flip-flop equivalence:
  - Stimulus: tap=0, en=1, vin=1, din sequence 0x3,0x9,0x5.
  - Required: dout follows one cycle later, vout=1.
- Max delay and full:
  - Stimulus: tap=7, en=1, vin=1, 8 samples 0x1..0x8.
  - Required: 0x1 appears after the 8th edge; full=1 from that point; no drop pulse.
  - Stimulus: a 9th sample.
  - Required: drop=1 for one cycle; cnt stays 8.
- Stall and tap change:
  - Stimulus: with the pipe loaded 0x1..0x8 (s[0]=0x8), set en=0 and load tap=2.
  - Required: dout=0x6 on the next cycle; the pipe is otherwise frozen.
  - Stimulus: en=0 for 5 cycles.
  - Required: dout holds.
- Bubbles and counter:
  - Stimulus: alternating vin=1/0 with en=1, 8 edges from empty.
  - Required: cnt=4, full=0, empty=0.
  - Stimulus: 8 edges with vin=0.
  - Required: empty=1; drop pulses on exactly 4 cycles.
- Clear priority:
  - Stimulus: sclr=1, en=1, tap_ld=1 with uio_in=0x5, all in the same cycle.
  - Required: all stages cleared, empty=1, drop=0, tap=5 retained.
  - Stimulus: the next enabled sample.
  - Required: it appears after 6 edges.

Source files
------------

// File: rtl/tt_delay_pkg.sv
// Shared definitions for the clock-enabled delay line tile: default sizing,
// pin bit positions on the Tiny Tapeout user ports, and the stage record.
package tt_delay_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_DEPTH = 8;
   localparam int MAX_WIDTH = 4;

   // ui_in control bit positions (data occupies [WIDTH-1:0])
   localparam int VIN   = 4;
   localparam int EN    = 5;
   localparam int SCLR  = 6;
   localparam int TAPLD = 7;

   // uo_out status bit positions (dout occupies [WIDTH-1:0])
   localparam int VOUT  = 4;
   localparam int FULL  = 5;
   localparam int EMPTY = 6;
   localparam int DROP  = 7;

   // One pipeline slot; data is sized for the widest legal WIDTH and the
   // bits above WIDTH are always held at zero by the top level.
   typedef struct packed {
      logic                 valid;
      logic [MAX_WIDTH-1:0] data;
   } stage_t;

endpackage

// File: rtl/delay_stage.sv
// One {valid, data} slot of the delay line with advance enable and
// synchronous clear; clear takes priority over advance.
module delay_stage
   import tt_delay_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   clr_i,
   input  logic   en_i,
   input  stage_t d_i,
   output stage_t q_o
);

   stage_t stage_q;

   // Reset, then clear, then advance; otherwise the slot holds.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else if (clr_i) begin
         stage_q <= '0;
      end else if (en_i) begin
         stage_q <= d_i;
      end
   end

   assign q_o = stage_q;

endmodule

// File: rtl/tt_um_murra232_delay_line.sv
// WIDTH-bit, DEPTH-stage delay line with per-sample valid bits, a run-time
// output tap, occupancy flags and a one-cycle drop pulse when a valid sample
// falls off the end of the pipe.
module tt_um_murra232_delay_line
   import tt_delay_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int TAPW = $clog2(DEPTH);
   localparam logic [TAPW:0] CNT_FULL = (TAPW+1)'(DEPTH);

   // Control decode
   logic vin, en, sclr, tap_ld;
   assign vin    = ui_in[VIN];
   assign en     = ui_in[EN];
   assign sclr   = ui_in[SCLR];
   assign tap_ld = ui_in[TAPLD];

   // Incoming sample, zero-padded above WIDTH so unused dout bits read 0.
   stage_t din_s;
   always_comb begin
      din_s                   = '0;
      din_s.valid             = vin;
      din_s.data[WIDTH-1:0]   = ui_in[WIDTH-1:0];
   end

   // Stage chain
   stage_t s_q [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         delay_stage u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (sclr),
            .en_i  (en),
            .d_i   (din_s),
            .q_o   (s_q[0])
         );
      end else begin : g_body
         delay_stage u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (sclr),
            .en_i  (en),
            .d_i   (s_q[i-1]),
            .q_o   (s_q[i])
         );
      end
   end

   logic last_vld;
   assign last_vld = s_q[DEPTH-1].valid;

   // Tap, occupancy and drop state
   logic [TAPW-1:0] tap_q;
   logic [TAPW:0]   cnt_q, cnt_d;
   logic            drop_q, drop_d;

   // Occupancy tracks net valid samples entering vs. leaving the whole pipe;
   // simultaneous in/out cancels, so the count can never leave 0..DEPTH.
   always_comb begin
      cnt_d  = cnt_q;
      drop_d = 1'b0;
      if (en) begin
         drop_d = last_vld;
         if (vin && !last_vld) begin
            cnt_d = cnt_q + 1'b1;
         end else if (!vin && last_vld) begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // Counter/drop obey reset > clear > advance; tap loads regardless of clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tap_q  <= '0;
         cnt_q  <= '0;
         drop_q <= 1'b0;
      end else begin
         if (sclr) begin
            cnt_q  <= '0;
            drop_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
         end
         if (tap_ld) begin
            tap_q <= uio_in[TAPW-1:0];
         end
      end
   end

   // Output tap is a pure mux off registered stages, so a new tap shows on
   // the cycle right after it is loaded, even while the pipe is stalled.
   stage_t tap_s;
   assign tap_s = s_q[tap_q];

   always_comb begin
      uo_out             = '0;
      uo_out[WIDTH-1:0]  = tap_s.data[WIDTH-1:0];
      uo_out[VOUT]       = tap_s.valid;
      uo_out[FULL]       = (cnt_q == CNT_FULL);
      uo_out[EMPTY]      = (cnt_q == '0);
      uo_out[DROP]       = drop_q;
   end

   assign uio_out = '0;
   assign uio_oe  = '0;

   // Pins the tile does not consume.
   logic unused_pins;
   assign unused_pins = &{1'b0, ena, ui_in, uio_in, tap_s.data};

endmodule

// File: tb/tb_tt_um_murra232_delay_line.sv
// Directed bench for the delay line tile: reset/flags, tap-0 flip-flop
// behaviour, max delay with full/drop, stall plus tap change, bubbles and
// the occupancy counter, clear priority, and reset mid-stream.
module tb_tt_um_murra232_delay_line;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tt_um_murra232_delay_line dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // ui_in = {tap_ld, sclr, en, vin, din}
   task automatic set_in(input logic vin, input logic en, input logic sclr,
                         input logic tld, input logic [3:0] din, input logic [7:0] tap);
      ui_in  = {tld, sclr, en, vin, din};
      uio_in = tap;
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int drops;

   initial begin
      ena   = 1'b1;
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 4'h0, 8'h00);

      // Reset and flags
      step(); step();
      chk("rst_uo", uo_out, 8'h40);
      chk("rst_uio_out", uio_out, 8'h00);
      chk("rst_uio_oe", uio_oe, 8'h00);
      rst_n = 1'b1;
      set_in(0, 0, 0, 0, 4'hF, 8'h00); step();
      chk("hold_din_f", uo_out, 8'h40);
      set_in(1, 0, 0, 0, 4'h0, 8'h00); step();
      chk("hold_din_0", uo_out, 8'h40);

      // Tap 0: plain flip-flop
      set_in(1, 1, 0, 0, 4'h3, 8'h00); step();
      chk("tap0_3", uo_out, 8'h13);
      set_in(1, 1, 0, 0, 4'h9, 8'h00); step();
      chk("tap0_9", uo_out, 8'h19);
      set_in(1, 1, 0, 0, 4'h5, 8'h00); step();
      chk("tap0_5", uo_out, 8'h15);

      // Clear, then load tap 7 while stalled
      set_in(0, 0, 1, 0, 4'h0, 8'h00); step();
      chk("sclr1", uo_out, 8'h40);
      set_in(0, 0, 0, 1, 4'h0, 8'h07); step();
      chk("tap7_ld", uo_out, 8'h40);

      // Max delay: 8 samples, only the 8th edge brings 0x1 out
      for (int k = 1; k <= 7; k++) begin
         set_in(1, 1, 0, 0, 4'(k), 8'h00); step();
         chk("fill", uo_out, 8'h00);
      end
      set_in(1, 1, 0, 0, 4'h8, 8'h00); step();
      chk("fill8_full", uo_out, 8'h31);

      // Stall and tap change: s[2]=0x6
      set_in(0, 0, 0, 1, 4'h0, 8'h02); step();
      chk("tap2_ld", uo_out, 8'h36);
      for (int k = 0; k < 5; k++) begin
         set_in(k[0], 0, 0, 0, 4'(k + 10), 8'h00); step();
         chk("stall_hold", uo_out, 8'h36);
      end
      set_in(0, 0, 0, 1, 4'h0, 8'h07); step();
      chk("tap7_back", uo_out, 8'h31);

      // 9th sample pushes 0x1 out: drop pulse, still full
      set_in(1, 1, 0, 0, 4'h9, 8'h00); step();
      chk("ninth_drop", uo_out, 8'hB2);
      set_in(0, 0, 0, 0, 4'h0, 8'h00); step();
      chk("drop_one_cyc", uo_out, 8'h32);

      // Bubbles: clear then alternate vin over 8 edges
      set_in(0, 0, 1, 0, 4'h0, 8'h00); step();
      chk("sclr2", uo_out, 8'h40);
      for (int k = 1; k <= 8; k++) begin
         set_in(k[0], 1, 0, 0, 4'(k), 8'h00); step();
      end
      chk("bub_half", uo_out, 8'h11);
      drops = 0;
      for (int k = 0; k < 8; k++) begin
         set_in(0, 1, 0, 0, 4'h0, 8'h00); step();
         chk("bub_drop", {31'd0, uo_out[7]}, {31'd0, (k % 2 == 0)});
         if (uo_out[7]) drops++;
      end
      chk("bub_drops", drops, 4);
      chk("bub_empty", uo_out, 8'h40);

      // Clear priority: sclr + en + tap_ld together
      set_in(1, 1, 0, 0, 4'hA, 8'h00); step();
      set_in(1, 1, 0, 0, 4'hA, 8'h00); step();
      set_in(1, 1, 1, 1, 4'hF, 8'h05); step();
      chk("clr_prio", uo_out, 8'h40);
      set_in(1, 1, 0, 0, 4'hC, 8'h00); step();
      chk("tap5_e1", uo_out, 8'h00);
      for (int k = 2; k <= 5; k++) begin
         set_in(0, 1, 0, 0, 4'h0, 8'h00); step();
         chk("tap5_wait", uo_out, 8'h00);
      end
      set_in(0, 1, 0, 0, 4'h0, 8'h00); step();
      chk("tap5_out", uo_out, 8'h1C);

      // Reset mid-stream clears tap as well
      rst_n = 1'b0;
      set_in(1, 1, 0, 0, 4'h3, 8'h00); step();
      chk("rst_mid", uo_out, 8'h40);
      rst_n = 1'b1;
      set_in(1, 1, 0, 0, 4'h7, 8'h00); step();
      chk("post_rst_tap0", uo_out, 8'h17);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
